// File: rtl/dp_dmi_dr.sv
// DMI data register for a RISC-V style debug transport: a serial shift register plus a
// request/response FSM toward the debug module. Define DP_DMI_TIMEOUT_EN to enable the 8-bit watchdog.
module dp_dmi_dr #(
  parameter int ABITS = 7
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             tdi,
  input  logic             capture_dr,
  input  logic             shift_dr,
  input  logic             update_dr,
  output logic             sdo,
  input  logic             dmi_reset,
  input  logic             dmi_hard_reset,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [ABITS-1:0] req_addr,
  output logic [31:0]      req_data,
  output logic [1:0]       req_op,
  input  logic             resp_valid,
  input  logic [31:0]      resp_data,
  input  logic [1:0]       resp_op,
  output logic             busy
);

  localparam int DRW = ABITS + 34;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [DRW-1:0]   sr_reg;
  logic [1:0]       state_reg, state_next;
  logic [1:0]       sticky_reg, sticky_next;
  logic [31:0]      rdata_reg;
  logic [ABITS-1:0] last_addr_reg;
  logic [ABITS-1:0] req_addr_reg;
  logic [31:0]      req_data_reg;
  logic [1:0]       req_op_reg;
  logic             start;
  logic             busy_err;
  logic             fail;
  logic             op_valid;
  logic [1:0]       status;

  assign busy      = (state_reg != S_IDLE);
  assign req_valid = (state_reg == S_REQ);
  assign sdo       = sr_reg[0];
  assign req_addr  = req_addr_reg;
  assign req_data  = req_data_reg;
  assign req_op    = req_op_reg;
  assign op_valid  = (sr_reg[1:0] == 2'd1) || (sr_reg[1:0] == 2'd2);
  assign status    = busy ? 2'd3 : sticky_reg;

`ifdef DP_DMI_TIMEOUT_EN
  logic [7:0] tcnt_reg;
  logic       timeout;

  assign timeout = busy && (tcnt_reg == 8'hff);

  // Restarts on every state entry, so REQ and WAIT each get a full window.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcnt_reg <= 8'd0;
    end else if (state_next != state_reg) begin
      tcnt_reg <= 8'd0;
    end else if (busy && (tcnt_reg != 8'hff)) begin
      tcnt_reg <= tcnt_reg + 8'd1;
    end
  end
`else
  logic timeout;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    sticky_next = sticky_reg;
    start       = 1'b0;
    busy_err    = 1'b0;
    fail        = 1'b0;

    case (state_reg)
      S_REQ:   if (req_ready) state_next = S_WAIT;
      S_WAIT:  if (resp_valid) begin
                 state_next = S_IDLE;
                 fail       = (resp_op == 2'd2);
               end
      default: state_next = state_reg;
    endcase

    if (timeout) begin
      state_next = S_IDLE;
      fail       = 1'b1;
    end

    if (update_dr) begin
      if (busy) begin
        busy_err = 1'b1;
      end else if (op_valid && (sticky_reg == 2'd0)) begin
        start      = 1'b1;
        state_next = S_REQ;
      end
    end else if (capture_dr && busy) begin
      busy_err = 1'b1;
    end

    // Set events override a coincident dmi_reset; hard reset overrides everything.
    if (dmi_reset) sticky_next = 2'd0;
    if (fail)      sticky_next = 2'd2;
    if (busy_err)  sticky_next = 2'd3;

    if (dmi_hard_reset) begin
      state_next  = S_IDLE;
      sticky_next = 2'd0;
      start       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr_reg        <= '0;
      state_reg     <= S_IDLE;
      sticky_reg    <= 2'd0;
      rdata_reg     <= 32'd0;
      last_addr_reg <= '0;
      req_addr_reg  <= '0;
      req_data_reg  <= 32'd0;
      req_op_reg    <= 2'd0;
    end else begin
      state_reg  <= state_next;
      sticky_reg <= sticky_next;

      if (update_dr) begin
        sr_reg <= sr_reg;
      end else if (capture_dr) begin
        sr_reg <= {last_addr_reg, rdata_reg, status};
      end else if (shift_dr) begin
        sr_reg <= {tdi, sr_reg[DRW-1:1]};
      end

      if (start) begin
        req_addr_reg  <= sr_reg[DRW-1:34];
        req_data_reg  <= sr_reg[33:2];
        req_op_reg    <= sr_reg[1:0];
        last_addr_reg <= sr_reg[DRW-1:34];
      end

      if ((state_reg == S_WAIT) && resp_valid && !dmi_hard_reset && !timeout) begin
        rdata_reg <= resp_data;
      end
    end
  end

endmodule

// File: tb/tb_dp_dmi_dr.sv
// Directed bench for dp_dmi_dr: a vector table of DMI transactions plus hand sequences
// for busy, failure recovery, hard reset, async reset and the optional timeout.
module tb_dp_dmi_dr;

  localparam int ABITS = 7;
  localparam int DRW   = ABITS + 34;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             tdi = 1'b0;
  logic             capture_dr = 1'b0;
  logic             shift_dr = 1'b0;
  logic             update_dr = 1'b0;
  logic             sdo;
  logic             dmi_reset = 1'b0;
  logic             dmi_hard_reset = 1'b0;
  logic             req_valid;
  logic             req_ready = 1'b0;
  logic [ABITS-1:0] req_addr;
  logic [31:0]      req_data;
  logic [1:0]       req_op;
  logic             resp_valid = 1'b0;
  logic [31:0]      resp_data = 32'd0;
  logic [1:0]       resp_op = 2'd0;
  logic             busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dp_dmi_dr #(.ABITS(ABITS)) dut (
    .clk(clk), .resetn(resetn), .tdi(tdi),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .sdo(sdo), .dmi_reset(dmi_reset), .dmi_hard_reset(dmi_hard_reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_op(req_op),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_op(resp_op),
    .busy(busy)
  );

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
    logic [1:0]  op;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_op;
    logic        exp_req;
    logic [6:0]  cap_addr;
    logic [31:0] cap_data;
    logic [1:0]  cap_st;
    logic        clr;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_in(input logic [6:0] a, input logic [31:0] d, input logic [1:0] o);
    logic [DRW-1:0] w;
    w = {a, d, o};
    shift_dr = 1'b1;
    for (int i = 0; i < DRW; i++) begin
      tdi = w[i];
      cyc();
    end
    shift_dr = 1'b0;
    tdi = 1'b0;
  endtask

  task automatic update();
    update_dr = 1'b1;
    cyc();
    update_dr = 1'b0;
  endtask

  task automatic capture_out(output logic [DRW-1:0] w);
    capture_dr = 1'b1;
    cyc();
    capture_dr = 1'b0;
    shift_dr = 1'b1;
    for (int i = 0; i < DRW; i++) begin
      w[i] = sdo;
      cyc();
    end
    shift_dr = 1'b0;
  endtask

  task automatic serve(input logic [31:0] d, input logic [1:0] o);
    req_ready = 1'b1;
    cyc();
    req_ready = 1'b0;
    resp_valid = 1'b1;
    resp_data = d;
    resp_op = o;
    cyc();
    resp_valid = 1'b0;
  endtask

  task automatic pulse_dmi_reset();
    dmi_reset = 1'b1;
    cyc();
    dmi_reset = 1'b0;
  endtask

  task automatic chk_cap(input string name, input logic [6:0] a, input logic [31:0] d,
                         input logic [1:0] s);
    logic [DRW-1:0] w;
    capture_out(w);
    chk({name, ".addr"}, 64'(w[DRW-1:34]), 64'(a));
    chk({name, ".data"}, 64'(w[33:2]), 64'(d));
    chk({name, ".status"}, 64'(w[1:0]), 64'(s));
  endtask

  initial begin
    int cnt;
    vecs[0] = '{7'h10, 32'hDEADBEEF, 2'd2, 32'h0000_0000, 2'd0, 1'b1, 7'h10, 32'h0000_0000, 2'd0, 1'b0};
    vecs[1] = '{7'h11, 32'h0000_0000, 2'd1, 32'h1234_5678, 2'd0, 1'b1, 7'h11, 32'h1234_5678, 2'd0, 1'b0};
    vecs[2] = '{7'h22, 32'h0000_00AA, 2'd0, 32'h0000_0000, 2'd0, 1'b0, 7'h11, 32'h1234_5678, 2'd0, 1'b0};
    vecs[3] = '{7'h33, 32'h0000_00BB, 2'd3, 32'h0000_0000, 2'd0, 1'b0, 7'h11, 32'h1234_5678, 2'd0, 1'b0};
    vecs[4] = '{7'h7F, 32'hFFFF_FFFF, 2'd2, 32'hA5A5_A5A5, 2'd0, 1'b1, 7'h7F, 32'hA5A5_A5A5, 2'd0, 1'b0};
    vecs[5] = '{7'h00, 32'h0000_0000, 2'd1, 32'h0000_0001, 2'd0, 1'b1, 7'h00, 32'h0000_0001, 2'd0, 1'b0};
    vecs[6] = '{7'h05, 32'h0000_0000, 2'd1, 32'hCAFE_F00D, 2'd2, 1'b1, 7'h05, 32'hCAFE_F00D, 2'd2, 1'b0};
    vecs[7] = '{7'h06, 32'h0000_0001, 2'd2, 32'h0000_0000, 2'd0, 1'b0, 7'h05, 32'hCAFE_F00D, 2'd2, 1'b1};
    vecs[8] = '{7'h06, 32'h0000_0001, 2'd2, 32'h0000_0000, 2'd0, 1'b1, 7'h06, 32'h0000_0000, 2'd0, 1'b0};

    // Reset state
    #12;
    chk("rst.sdo", 64'(sdo), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.req_valid", 64'(req_valid), 64'd0);
    chk("rst.req_payload", 64'({req_addr, req_data, req_op}), 64'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    cyc();
    chk_cap("rst.cap", 7'h00, 32'h0, 2'd0);

    // Vector table
    foreach (vecs[k]) begin
      string nm;
      nm = $sformatf("vec%0d", k);
      chk({nm, ".idle"}, 64'(busy), 64'd0);
      shift_in(vecs[k].addr, vecs[k].data, vecs[k].op);
      update();
      chk({nm, ".req_valid"}, 64'(req_valid), 64'(vecs[k].exp_req));
      if (vecs[k].exp_req) begin
        chk({nm, ".req_addr"}, 64'(req_addr), 64'(vecs[k].addr));
        chk({nm, ".req_data"}, 64'(req_data), 64'(vecs[k].data));
        chk({nm, ".req_op"}, 64'(req_op), 64'(vecs[k].op));
        serve(vecs[k].rsp_data, vecs[k].rsp_op);
        chk({nm, ".busy_done"}, 64'(busy), 64'd0);
      end
      chk_cap({nm, ".cap"}, vecs[k].cap_addr, vecs[k].cap_data, vecs[k].cap_st);
      if (vecs[k].clr) pulse_dmi_reset();
    end

    // Busy: capture and update while the request is stalled
    shift_in(7'h20, 32'h11, 2'd2);
    update();
    repeat (3) cyc();
    chk("busy.req_valid", 64'(req_valid), 64'd1);
    chk("busy.payload", 64'({req_addr, req_data}), 64'({7'h20, 32'h11}));
    chk_cap("busy.cap", 7'h20, 32'h0, 2'd3);
    shift_in(7'h21, 32'h22, 2'd2);
    update();
    chk("busy.drop", 64'({req_addr, req_data}), 64'({7'h20, 32'h11}));
    pulse_dmi_reset();
    serve(32'h55, 2'd0);
    chk("busy.done", 64'(busy), 64'd0);
    chk_cap("busy.recover", 7'h20, 32'h55, 2'd0);

    // Hard reset while in WAIT, then a late response
    shift_in(7'h30, 32'h0, 2'd1);
    update();
    req_ready = 1'b1;
    cyc();
    req_ready = 1'b0;
    chk("hard.wait_busy", 64'({busy, req_valid}), 64'b10);
    dmi_hard_reset = 1'b1;
    cyc();
    dmi_hard_reset = 1'b0;
    chk("hard.busy", 64'(busy), 64'd0);
    resp_valid = 1'b1;
    resp_data = 32'h0000_0BAD;
    resp_op = 2'd0;
    cyc();
    resp_valid = 1'b0;
    chk_cap("hard.late_resp", 7'h30, 32'h55, 2'd0);

    // Hard reset wins over a coincident update
    shift_in(7'h40, 32'h9, 2'd2);
    update_dr = 1'b1;
    dmi_hard_reset = 1'b1;
    cyc();
    update_dr = 1'b0;
    dmi_hard_reset = 1'b0;
    chk("hard_vs_upd", 64'({busy, req_valid}), 64'd0);
    chk_cap("hard_vs_upd.cap", 7'h30, 32'h55, 2'd0);

    // Async reset mid-transaction
    shift_in(7'h41, 32'h7, 2'd2);
    update();
    chk("arst.pre", 64'(req_valid), 64'd1);
    #3 resetn = 1'b0;
    #1;
    chk("arst.req_valid", 64'({req_valid, busy, sdo}), 64'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    resp_valid = 1'b1;
    resp_data = 32'hFEED_FACE;
    cyc();
    resp_valid = 1'b0;
    chk_cap("arst.cap", 7'h00, 32'h0, 2'd0);

    // Stalled request: watchdog or indefinite wait
    shift_in(7'h50, 32'h3, 2'd2);
    update();
`ifdef DP_DMI_TIMEOUT_EN
    cnt = 0;
    while (busy && cnt < 300) begin
      cyc();
      cnt++;
    end
    chk("tmo.window", 64'((cnt >= 250) && (cnt <= 260)), 64'd1);
    chk("tmo.req_valid", 64'(req_valid), 64'd0);
    chk_cap("tmo.cap", 7'h50, 32'h0, 2'd2);
    pulse_dmi_reset();
`else
    cnt = 0;
    repeat (1000) begin
      cyc();
      cnt++;
    end
    chk("notmo.busy", 64'({busy, req_valid}), 64'b11);
    dmi_hard_reset = 1'b1;
    cyc();
    dmi_hard_reset = 1'b0;
    chk("notmo.abort", 64'(busy), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
